// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB with memory handshakes
module multicycle_ctrl #(
  parameter int OP_W = 6,
  parameter int ALUOP_W = 5,
  parameter int MEM_TO = 16,
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               imem_ready_i,
  input  logic               dmem_ready_i,
  output logic               IMemReq_o,
  output logic               IRWrite_o,
  output logic               PCWrite_o,
  output logic               DMemReq_o,
  output logic               MemWrite_o,
  output logic [1:0]         MemNum_o,
  output logic               UnSigned_o,
  output logic               RegDst_o,
  output logic               ALUSrc_o,
  output logic               MemtoReg_o,
  output logic               Branch_o,
  output logic               Jump_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   instret_o,
  output logic               halt_o,
  output logic               illegal_o,
  output logic               bus_err_o
);
  localparam int TO_W = $clog2(MEM_TO);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_t;
  state_t state, stateNext;
  logic [OP_W-1:0] opQ;
  logic [TO_W-1:0] toCnt;
  logic isR, isImm, isLoad, isStore, isBranch, isJ, isJal, opDefined, isHalt;
  logic waiting, timedOut, active, retire;
  logic [1:0] memNum;
  logic [ALUOP_W-1:0] aluOp;
  always_comb begin
    isR       = opQ == 6'h00;
    isImm     = opQ inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    isLoad    = opQ inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    isStore   = opQ inside {6'h28, 6'h29, 6'h2B};
    isBranch  = opQ inside {6'h04, 6'h05, 6'h07};
    isJ       = opQ == 6'h02;
    isJal     = opQ == 6'h03;
    isHalt    = instr_op_i == 6'h3F;
    opDefined = instr_op_i inside {6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                   6'h04, 6'h05, 6'h07, 6'h02, 6'h03, 6'h20, 6'h21, 6'h23,
                                   6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    memNum    = opQ inside {6'h23, 6'h2B} ? 2'b11 :
                opQ inside {6'h21, 6'h25, 6'h29} ? 2'b10 :
                opQ inside {6'h20, 6'h24, 6'h28} ? 2'b01 : 2'b00;
  end
  always_comb begin
    aluOp = '0;
    case (opQ)
      6'h08, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: aluOp = 5'h01;
      6'h09: aluOp = 5'h02;
      6'h0A: aluOp = 5'h09;
      6'h0C: aluOp = 5'h04;
      6'h0D: aluOp = 5'h05;
      6'h0E: aluOp = 5'h07;
      6'h0F: aluOp = 5'h11;
      6'h04: aluOp = 5'h0D;
      6'h05: aluOp = 5'h0E;
      6'h07: aluOp = 5'h0F;
      6'h02, 6'h03: aluOp = 5'h10;
      default: aluOp = 5'h00;
    endcase
  end
  // ready arriving in the final allowed cycle still wins over the timeout
  always_comb begin
    waiting  = (state == FETCH && !imem_ready_i) || (state == MEM && !dmem_ready_i);
    timedOut = waiting && toCnt == TO_W'(MEM_TO - 1);
  end
  always_comb begin
    stateNext = state;
    unique case (state)
      FETCH:   stateNext = imem_ready_i ? DECODE : timedOut ? HALTED : FETCH;
      DECODE:  stateNext = isHalt ? HALTED : opDefined ? EXEC : FETCH;
      EXEC:    stateNext = (isLoad || isStore) ? MEM : (isBranch || isJ || isJal) ? FETCH : WB;
      MEM:     stateNext = dmem_ready_i ? (isLoad ? WB : FETCH) : timedOut ? HALTED : MEM;
      WB:      stateNext = FETCH;
      default: stateNext = HALTED;
    endcase
  end
  always_comb begin
    active     = state inside {EXEC, MEM, WB};
    retire     = active && stateNext == FETCH;
    IMemReq_o  = state == FETCH;
    IRWrite_o  = state == FETCH && imem_ready_i;
    PCWrite_o  = state == FETCH && imem_ready_i;
    DMemReq_o  = state == MEM;
    MemWrite_o = state == MEM && isStore;
    RegWrite_o = state == WB || (state == EXEC && isJal);
    Branch_o   = state == EXEC && isBranch;
    Jump_o     = state == EXEC && (isJ || isJal);
    RegDst_o   = active && isR;
    ALUSrc_o   = active && (isImm || isLoad || isStore);
    MemtoReg_o = active && isLoad;
    UnSigned_o = active && opQ inside {6'h09, 6'h24, 6'h25};
    MemNum_o   = active ? memNum : 2'b00;
    ALU_op_o   = active ? aluOp : '0;
    state_o    = state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= FETCH;
      opQ       <= '0;
      toCnt     <= '0;
      instret_o <= '0;
      halt_o    <= 1'b0;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= stateNext;
      if (state == DECODE) opQ <= instr_op_i;
      toCnt     <= (stateNext != state && (stateNext == FETCH || stateNext == MEM)) ? '0 :
                   (waiting && !timedOut) ? toCnt + 1'b1 : toCnt;
      if (retire) instret_o <= instret_o + 1'b1;
      illegal_o <= state == DECODE && !opDefined && !isHalt;
      halt_o    <= halt_o || stateNext == HALTED;
      bus_err_o <= bus_err_o || timedOut;
    end
  end
endmodule
